dds_nco: RTL and testbench
==========================

# dds_nco

Parametrised numerically controlled oscillator and the next-generation DDS core. It provides a configurable-width phase accumulator, a phase-offset adder and a registered waveform generator with four modes: sawtooth, triangle, square and PWM. Frequency, phase, mode and duty are taken atomically through a load strobe, so retuning never produces a torn setting. It sits between the control/register block and the DAC or output pin logic.

## Interface
- ACC_W, 32, phase accumulator width (frequency word width)
- PHASE_W, 11, truncated phase width; also the phase-offset and duty width (≥2)
- OUT_W, 11, waveform output width (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  accumulator advance enable
- load  in  1  capture strobe for freq_word, phase_word, mode and duty
- freq_word  in  ACC_W  phase increment per enabled cycle
- phase_word  in  PHASE_W  phase offset added after truncation
- mode  in  2  waveform select: 0 saw, 1 triangle, 2 square, 3 PWM
- duty  in  PHASE_W  PWM threshold
- wave_out  out  OUT_W  registered waveform sample
- sq_out  out  1  MSB of the offset phase (50% square), aligned with wave_out
- wrap_pulse  out  1  one-cycle pulse marking an accumulator wrap, aligned with wave_out
- out_valid  out  1  wave_out corresponds to an enabled accumulator step

## Operation
- Active registers r_freq, r_phase, r_mode and r_duty are loaded from the inputs on any edge where load=1. There is no handshake and load is always accepted.
- Stage A, accumulator: at each edge with en=1, acc <= (acc + r_freq) mod 2^ACC_W. carry = carry-out of this add. With en=0, acc holds and carry=0.
- Stage B, phase: ph <= (acc[ACC_W-1 -: PHASE_W] + r_phase) mod 2^PHASE_W. Stage B runs every cycle, independent of en.
- Stage C, wave: a value v of PHASE_W bits is produced per mode:
  - saw: v = ph
  - triangle: t = ph[MSB] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0]; v = {t,1'b0}
  - square: v = ph[MSB] ? all-ones : 0
  - PWM: v = (ph < r_duty) ? all-ones : 0 (unsigned compare; duty=0 gives constant 0)
- Width scaling: if OUT_W≥PHASE_W, wave_out = v << (OUT_W-PHASE_W); otherwise wave_out = v >> (PHASE_W-OUT_W).
- sq_out <= ph[MSB]. wrap_pulse and out_valid are carry and en delayed to align with wave_out.
- freq_word=0 with en=1: acc is constant and wrap_pulse never asserts.

## Timing
- Reset values: acc, ph, all r_* registers, wave_out, sq_out, wrap_pulse and out_valid are 0. A mid-operation reset clears everything immediately, asynchronously.
- load at edge N: the new r_freq first accumulates at edge N+1. The new r_phase, r_mode and r_duty affect ph and wave_out from edge N+1 and N+2.
- load and en in the same cycle: the accumulation at that edge uses the old r_freq.
- Latency: an acc update at edge N appears on wave_out, sq_out and wrap_pulse at edge N+2.
- out_valid at edge N+2 equals en sampled at edge N.
- en low: wave_out holds the last phase value but still tracks changes to mode and phase.

## Configuration
- DDS_NCO_PHASE_CLR_EN:
  - Defined: adds input port phase_clr (1 bit). phase_clr=1 sets acc to 0 at the next edge, overriding en, and carry=0. A simultaneous load is still applied.
  - Undefined: the port is absent and acc changes only through accumulation and reset.

## Test plan
All scenarios use default parameters.
- Reset, then load freq=0x4000_0000, phase=0, mode=0, en=1 -> wave_out sequence 512, 1024, 1536, 0 repeating; wrap_pulse high on each 0 sample; out_valid high from the 2nd edge after en.
- Same frequency, load phase=1024 -> saw sequence 1536, 0, 512, 1024; sq_out 1, 0, 0, 1.
- mode=1 with the same frequency and phase=0 -> triangle 1024, 2046, 1022, 0 repeating.
- mode=3, duty=512 -> wave_out 2047 only on ph=0 samples, otherwise 0. duty=0 -> constant 0.
- Retune mid-run: freq 0x4000_0000 -> 0x2000_0000 with load and en together -> one more step of 512, then steps of 256. en=0 for 3 cycles -> wave_out frozen and out_valid low after 2 cycles.
- Assert rst_n low mid-run -> all outputs 0 asynchronously. With DDS_NCO_PHASE_CLR_EN, a phase_clr pulse -> saw restarts at 0 two cycles later.

Source files
------------

// File: rtl/dds_nco.sv
// -----------------------------------------------------------------------------
// dds_nco -- numerically controlled oscillator / DDS core
//
// A phase accumulator advances by a frequency word on every enabled cycle.
// Its top PHASE_W bits are offset by a phase word to give the output phase.
// A registered waveform generator turns that phase into a sawtooth, triangle,
// square or PWM sample.
//
// Frequency, phase, mode and duty are captured together on a load strobe. The
// active setting therefore always changes as a single unit.
//
// Pipeline (edge N = accumulator update):
//   N   : acc_q                (stage A)
//   N+1 : ph_q                 (stage B, runs every cycle)
//   N+2 : wave_out, sq_out, wrap_pulse, out_valid   (stage C)
//
// Parameters
//   ACC_W    phase accumulator / frequency word width
//   PHASE_W  truncated phase width, also phase-offset and duty width (>= 2)
//   OUT_W    waveform output width (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          accumulator advance enable
//   load        capture strobe for freq_word / phase_word / mode / duty
//   freq_word   phase increment per enabled cycle
//   phase_word  phase offset added after truncation
//   mode        0 saw, 1 triangle, 2 square, 3 PWM
//   duty        PWM threshold
//   phase_clr   (only with DDS_NCO_PHASE_CLR_EN) clears the accumulator
//   wave_out    registered waveform sample
//   sq_out      MSB of the offset phase, aligned with wave_out
//   wrap_pulse  accumulator wrap marker, aligned with wave_out
//   out_valid   wave_out comes from an enabled accumulator step
//
// Optional feature macro: DDS_NCO_PHASE_CLR_EN
//   When this macro is defined, the phase_clr input port is added. While
//   phase_clr is high, the accumulator is forced to zero at the next edge.
//   This overrides en and suppresses the carry.
// -----------------------------------------------------------------------------
module dds_nco #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 11,
    parameter int OUT_W   = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [ACC_W-1:0]   freq_word,
    input  logic [PHASE_W-1:0] phase_word,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] duty,
`ifdef DDS_NCO_PHASE_CLR_EN
    input  logic               phase_clr,
`endif
    output logic [OUT_W-1:0]   wave_out,
    output logic               sq_out,
    output logic               wrap_pulse,
    output logic               out_valid
);

    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQ  = 2'd2,
        MODE_PWM = 2'd3
    } wave_mode_e;

    // ------------------------------------------------------------------------
    // Active configuration registers, captured atomically on load
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0]   r_freq_q;
    logic [PHASE_W-1:0] r_phase_q;
    wave_mode_e         r_mode_q;
    logic [PHASE_W-1:0] r_duty_q;

    // NOTE: sequential state is written only with non-blocking assignments, so
    // every register samples the pre-edge value of its neighbours. A stage may
    // then read the previous stage's output without any race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq_q  <= '0;
            r_phase_q <= '0;
            r_mode_q  <= MODE_SAW;
            r_duty_q  <= '0;
        end else if (load) begin
            r_freq_q  <= freq_word;
            r_phase_q <= phase_word;
            r_mode_q  <= wave_mode_e'(mode);
            r_duty_q  <= duty;
        end
    end

    // ------------------------------------------------------------------------
    // Stage A: phase accumulator
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             carry_d;
    logic             clr_req;

`ifdef DDS_NCO_PHASE_CLR_EN
    assign clr_req = phase_clr;
`else
    assign clr_req = 1'b0;
`endif

    // The extra top bit of the sum is the carry out of the modular add.
    assign acc_sum = {1'b0, acc_q} + {1'b0, r_freq_q};

    // NOTE: every output of this block receives a default before any branch.
    // Without those defaults, synthesis would infer a latch for each path
    // that leaves an output unassigned.
    always_comb begin
        acc_d   = acc_q;
        carry_d = 1'b0;
        if (clr_req) begin
            acc_d = '0;
        end else if (en) begin
            acc_d   = acc_sum[ACC_W-1:0];
            carry_d = acc_sum[ACC_W];
        end
    end

    // ------------------------------------------------------------------------
    // Stage B: truncate and add the phase offset (wraps mod 2^PHASE_W)
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0] ph_q, ph_d;

    assign ph_d = acc_q[ACC_W-1 -: PHASE_W] + r_phase_q;

    // ------------------------------------------------------------------------
    // Stage C: waveform shaping and width scaling
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0] wave_v;
    logic [PHASE_W-2:0] tri_t;
    logic [OUT_W-1:0]   wave_d;

    // The triangle folds the upper half of the phase back down. Doubling the
    // folded value restores the full PHASE_W range.
    assign tri_t = ph_q[PHASE_W-1] ? ~ph_q[PHASE_W-2:0] : ph_q[PHASE_W-2:0];

    always_comb begin
        wave_v = '0;
        unique case (r_mode_q)
            MODE_SAW: wave_v = ph_q;
            MODE_TRI: wave_v = {tri_t, 1'b0};
            MODE_SQ:  wave_v = {PHASE_W{ph_q[PHASE_W-1]}};
            MODE_PWM: wave_v = {PHASE_W{(ph_q < r_duty_q)}};
            default:  wave_v = '0;
        endcase
    end

    generate
        if (OUT_W >= PHASE_W) begin : g_widen
            localparam int SHIFT = OUT_W - PHASE_W;
            assign wave_d = OUT_W'(wave_v) << SHIFT;
        end else begin : g_narrow
            localparam int SHIFT = PHASE_W - OUT_W;
            assign wave_d = OUT_W'(wave_v >> SHIFT);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    // carry/en pass through two stages (stage A, stage B). The flags then land
    // on wrap_pulse/out_valid at the same edge as the wave sample they describe.
    logic carry_a_q, carry_b_q;
    logic en_a_q, en_b_q;
    logic [OUT_W-1:0] wave_q;
    logic sq_q, wrap_q, valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            ph_q      <= '0;
            carry_a_q <= 1'b0;
            carry_b_q <= 1'b0;
            en_a_q    <= 1'b0;
            en_b_q    <= 1'b0;
            wave_q    <= '0;
            sq_q      <= 1'b0;
            wrap_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ph_q      <= ph_d;
            carry_a_q <= carry_d;
            carry_b_q <= carry_a_q;
            en_a_q    <= en;
            en_b_q    <= en_a_q;
            wave_q    <= wave_d;
            sq_q      <= ph_q[PHASE_W-1];
            wrap_q    <= carry_b_q;
            valid_q   <= en_b_q;
        end
    end

    assign wave_out   = wave_q;
    assign sq_out     = sq_q;
    assign wrap_pulse = wrap_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_dds_nco.sv
// -----------------------------------------------------------------------------
// tb_dds_nco -- scoreboard bench for dds_nco (default parameters).
//
// The driver applies stimulus. After every rising edge, it advances a
// behavioural model of the oscillator and pushes the expected outputs for that
// edge into a queue. A monitor on the falling edge pops that queue and compares
// against the DUT.
// -----------------------------------------------------------------------------
module tb_dds_nco;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 11;
    localparam int OUT_W   = 11;
    localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;
    localparam int PH_MOD   = 1 << PHASE_W;
    localparam int PH_HALF  = PH_MOD / 2;
    localparam int WAVE_MAX = (1 << OUT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               load;
    logic [ACC_W-1:0]   freq_word;
    logic [PHASE_W-1:0] phase_word;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] duty;
`ifdef DDS_NCO_PHASE_CLR_EN
    logic               phase_clr;
`endif
    logic [OUT_W-1:0]   wave_out;
    logic               sq_out;
    logic               wrap_pulse;
    logic               out_valid;

    dds_nco #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .freq_word  (freq_word),
        .phase_word (phase_word),
        .mode       (mode),
        .duty       (duty),
`ifdef DDS_NCO_PHASE_CLR_EN
        .phase_clr  (phase_clr),
`endif
        .wave_out   (wave_out),
        .sq_out     (sq_out),
        .wrap_pulse (wrap_pulse),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------------
    typedef struct {
        int wave;
        int sq;
        int wrap;
        int valid;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wave_out",   int'(wave_out),   e.wave);
                check("sq_out",     int'(sq_out),     e.sq);
                check("wrap_pulse", int'(wrap_pulse), e.wrap);
                check("out_valid",  int'(out_valid),  e.valid);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: plain arithmetic on the phase, in the oscillator's terms
    // ------------------------------------------------------------------------
    longint unsigned m_acc;
    int  m_ph;
    longint unsigned m_freq;
    int  m_phase, m_mode, m_duty;
    int  m_carry_hist[$];   // carry from each edge, oldest first
    int  m_en_hist[$];      // en sampled at each edge, oldest first

    function automatic int wave_of(input int ph, input int md, input int dt);
        case (md)
            0: return ph;
            1: return (ph < PH_HALF ? ph : PH_MOD - 1 - ph) * 2;
            2: return (ph >= PH_HALF) ? WAVE_MAX : 0;
            default: return (ph < dt) ? WAVE_MAX : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ph = 0; m_freq = 0;
        m_phase = 0; m_mode = 0; m_duty = 0;
        m_carry_hist = '{0, 0};
        m_en_hist    = '{0, 0};
    endtask

    // One rising edge. The inputs are the values the DUT just sampled.
    task automatic step();
        exp_t e;
        longint unsigned sum;
        int carry;
        bit clr;
        @(posedge clk);
        clr = 1'b0;
`ifdef DDS_NCO_PHASE_CLR_EN
        clr = phase_clr;
`endif
        // Outputs at this edge come from the phase held before it.
        e.wave  = wave_of(m_ph, m_mode, m_duty);
        e.sq    = (m_ph >= PH_HALF) ? 1 : 0;
        e.wrap  = m_carry_hist.pop_front();
        e.valid = m_en_hist.pop_front();
        sb.push_back(e);
        // Phase from the accumulator value before this edge.
        m_ph = int'((m_acc >> (ACC_W - PHASE_W)) + longint'(m_phase)) % PH_MOD;
        carry = 0;
        if (clr) begin
            m_acc = 0;
        end else if (en) begin
            sum   = m_acc + m_freq;
            carry = (sum >= ACC_MOD) ? 1 : 0;
            m_acc = sum % ACC_MOD;
        end
        m_carry_hist.push_back(carry);
        m_en_hist.push_back(int'(en));
        if (load) begin
            m_freq  = longint'(freq_word);
            m_phase = int'(phase_word);
            m_mode  = int'(mode);
            m_duty  = int'(duty);
        end
        #1;
    endtask

    task automatic drive(input bit e, input bit l, input logic [ACC_W-1:0] f,
                         input int p, input int m, input int d);
        en = e; load = l; freq_word = f;
        phase_word = PHASE_W'(p); mode = 2'(m); duty = PHASE_W'(d);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wave"},  int'(wave_out),   0);
        check({tag, "_sq"},    int'(sq_out),     0);
        check({tag, "_wrap"},  int'(wrap_pulse), 0);
        check({tag, "_valid"}, int'(out_valid),  0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, 0, 0, 0);
`ifdef DDS_NCO_PHASE_CLR_EN
        phase_clr = 1'b0;
`endif
        model_reset();
        #3;
        check_all_zero("reset");
        #9;             // t=12: between edges
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Load 1/4-cycle frequency, sawtooth, then run.
        drive(0, 1, 32'h4000_0000, 0, 0, 0);
        step();
        drive(1, 0, 32'h4000_0000, 0, 0, 0);
        run(16);

        // Phase offset of half a cycle.
        drive(1, 1, 32'h4000_0000, 1024, 0, 0);
        step();
        drive(1, 0, 32'h4000_0000, 1024, 0, 0);
        run(8);

        // Triangle.
        drive(1, 1, 32'h4000_0000, 0, 1, 0);
        step();
        drive(1, 0, 32'h4000_0000, 0, 1, 0);
        run(8);

        // Square.
        drive(1, 1, 32'h4000_0000, 0, 2, 0);
        step();
        drive(1, 0, 32'h4000_0000, 0, 2, 0);
        run(8);

        // PWM with duty 512, then duty 0.
        drive(1, 1, 32'h4000_0000, 0, 3, 512);
        step();
        drive(1, 0, 32'h4000_0000, 0, 3, 512);
        run(8);
        drive(1, 1, 32'h4000_0000, 0, 3, 0);
        step();
        drive(1, 0, 32'h4000_0000, 0, 3, 0);
        run(8);

        // Retune with load and en together, then pause en for 3 cycles.
        drive(1, 1, 32'h2000_0000, 0, 0, 0);
        step();
        drive(1, 0, 32'h2000_0000, 0, 0, 0);
        run(10);
        drive(0, 0, 32'h2000_0000, 0, 0, 0);
        run(3);
        drive(1, 0, 32'h2000_0000, 0, 0, 0);
        run(6);

        // Zero frequency: the accumulator holds and never wraps.
        drive(1, 1, '0, 0, 0, 0);
        step();
        drive(1, 0, '0, 0, 0, 0);
        run(8);

        // Mid-run asynchronous reset, asserted between edges.
        drive(1, 1, 32'h4000_0000, 0, 0, 0);
        step();
        drive(1, 0, 32'h4000_0000, 0, 0, 0);
        run(5);
        mon_en = 1'b0;
        sb.delete();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drive(1, 1, 32'h4000_0000, 0, 0, 0);
        step();
        drive(1, 0, 32'h4000_0000, 0, 0, 0);
        run(6);

`ifdef DDS_NCO_PHASE_CLR_EN
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        run(6);
`endif

        // Randomised retuning, modes and enable.
        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(0, 7) != 0);
            load       = ($urandom_range(0, 15) == 0);
            freq_word  = $urandom();
            phase_word = PHASE_W'($urandom());
            mode       = 2'($urandom());
            duty       = PHASE_W'($urandom());
`ifdef DDS_NCO_PHASE_CLR_EN
            phase_clr  = ($urandom_range(0, 63) == 0);
`endif
            step();
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
